// File: rtl/rv32i_cpu_mc_pkg.sv
// Shared definitions for the rv32i_cpu_mc multicycle core: FSM state
// encodings, trap cause codes, opcodes, load/store funct3 codes, store
// byte-lane masks, write-back source select and the ALU evaluation helper.
package rv32i_cpu_mc_pkg;

    typedef enum logic [2:0] {
        CPU_ST_IDLE       = 3'd0,
        CPU_ST_FETCH      = 3'd1,
        CPU_ST_DECODE     = 3'd2,
        CPU_ST_EXECUTE    = 3'd3,
        CPU_ST_MEM        = 3'd4,
        CPU_ST_WRITE_BACK = 3'd5,
        CPU_ST_HALT       = 3'd6
    } cpu_state_e;

    localparam logic [1:0] TRAP_NONE          = 2'd0;
    localparam logic [1:0] TRAP_ILLEGAL       = 2'd1;
    localparam logic [1:0] TRAP_MISALIGN_DATA = 2'd2;
    localparam logic [1:0] TRAP_MISALIGN_PC   = 2'd3;

    localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
    localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
    localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
    localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
    localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
    localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPCODE_OP     = 7'b0110011;

    // Load funct3 codes; stores use the same size encoding in funct3[1:0].
    localparam logic [2:0] MEM_RD_B  = 3'b000;
    localparam logic [2:0] MEM_RD_H  = 3'b001;
    localparam logic [2:0] MEM_RD_W  = 3'b010;
    localparam logic [2:0] MEM_RD_BU = 3'b100;
    localparam logic [2:0] MEM_RD_HU = 3'b101;

    localparam logic [3:0] STORE_MASK_B = 4'b0001;
    localparam logic [3:0] STORE_MASK_H = 4'b0011;
    localparam logic [3:0] STORE_MASK_W = 4'b1111;

    typedef enum logic [1:0] {
        REG_SRC_ALU = 2'd0,
        REG_SRC_MEM = 2'd1,
        REG_SRC_PC4 = 2'd2
    } reg_src_e;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_op_e;

    function automatic logic [31:0] alu_eval(alu_op_e op, logic [31:0] a, logic [31:0] b);
        logic [31:0] r;
        r = 32'h0;
        case (op)
            ALU_ADD:  r = a + b;
            ALU_SUB:  r = a - b;
            ALU_SLL:  r = a << b[4:0];
            ALU_SLT:  r = {31'b0, ($signed(a) < $signed(b))};
            ALU_SLTU: r = {31'b0, (a < b)};
            ALU_XOR:  r = a ^ b;
            ALU_SRL:  r = a >> b[4:0];
            ALU_SRA:  r = $unsigned($signed(a) >>> b[4:0]);
            ALU_OR:   r = a | b;
            ALU_AND:  r = a & b;
            default:  r = 32'h0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/rv32i_cpu_mc_mem_align.sv
// Byte-lane alignment for the data port: builds the store lane mask and the
// lane-replicated store word, and extracts/extends load data from the word.
import rv32i_cpu_mc_pkg::*;

module rv32i_cpu_mc_mem_align (
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  byte_off_i,
    input  logic [31:0] store_src_i,
    input  logic [31:0] load_word_i,
    output logic [3:0]  store_mask_o,
    output logic [31:0] store_data_o,
    output logic [31:0] load_data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Store lane mask and replicated store data by access size
    always_comb begin
        store_mask_o = STORE_MASK_W;
        store_data_o = store_src_i;
        case (funct3_i[1:0])
            2'b00: begin
                store_mask_o = STORE_MASK_B << byte_off_i;
                store_data_o = {4{store_src_i[7:0]}};
            end
            2'b01: begin
                store_mask_o = STORE_MASK_H << byte_off_i;
                store_data_o = {2{store_src_i[15:0]}};
            end
            default: begin
                store_mask_o = STORE_MASK_W;
                store_data_o = store_src_i;
            end
        endcase
    end

    // Load lane select followed by sign/zero extension
    always_comb begin
        byte_sel    = load_word_i[7:0];
        half_sel    = byte_off_i[1] ? load_word_i[31:16] : load_word_i[15:0];
        load_data_o = load_word_i;
        case (byte_off_i)
            2'd0:    byte_sel = load_word_i[7:0];
            2'd1:    byte_sel = load_word_i[15:8];
            2'd2:    byte_sel = load_word_i[23:16];
            default: byte_sel = load_word_i[31:24];
        endcase
        case (funct3_i)
            MEM_RD_B:  load_data_o = {{24{byte_sel[7]}}, byte_sel};
            MEM_RD_BU: load_data_o = {24'h0, byte_sel};
            MEM_RD_H:  load_data_o = {{16{half_sel[15]}}, half_sel};
            MEM_RD_HU: load_data_o = {16'h0, half_sel};
            default:   load_data_o = load_word_i;
        endcase
    end

endmodule

// File: rtl/rv32i_cpu_mc.sv
// Multicycle RV32I core with handshaked instruction/data ports, byte-lane
// aligned loads/stores and trap-to-halt on illegal or misaligned accesses.
// Optional performance counters are enabled by defining RV32I_CPU_PERF_CNT_EN.
import rv32i_cpu_mc_pkg::*;

module rv32i_cpu_mc #(
    parameter int          IMEM_WIDTH = 16,
    parameter int          DMEM_WIDTH = 16,
    parameter logic [31:0] RESET_PC   = 32'h0
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  inst_req,
    output logic [IMEM_WIDTH-1:0] inst_addr,
    input  logic                  inst_valid,
    input  logic [31:0]           instruction_data,
    output logic                  data_req,
    output logic [DMEM_WIDTH-1:0] data_addr,
    output logic [3:0]            data_we,
    output logic [31:0]           data_write,
    input  logic [31:0]           data_read,
    input  logic                  data_valid,
    output logic                  halted,
    output logic [1:0]            trap_cause
`ifdef RV32I_CPU_PERF_CNT_EN
    ,
    output logic [63:0]           cycle_count,
    output logic [63:0]           instret_count
`endif
);

    cpu_state_e            state_q;
    logic [31:0]           pc_q, ir_q, next_pc_q, wb_q;
    logic [31:0]           rf_q [32];
    logic                  inst_req_q, data_req_q, halted_q;
    logic [IMEM_WIDTH-1:0] inst_addr_q;
    logic [DMEM_WIDTH-1:0] data_addr_q;
    logic [3:0]            data_we_q;
    logic [31:0]           data_write_q;
    logic [1:0]            trap_q;

    logic [6:0]  opcode, funct7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm;
    logic        legal, is_load, is_store, is_branch, is_jal, is_jalr, writes_rd;
    logic        src_a_pc, src_a_zero, src_b_imm;
    reg_src_e    reg_src;
    alu_op_e     alu_op;

    logic [31:0]           rs1_val, rs2_val, op_a, op_b, alu_res, pc4;
    logic [31:0]           next_pc_d, wb_d;
    logic                  taken, redirect, misalign_data, misalign_pc, rf_we;
    logic [DMEM_WIDTH-1:0] eff;
    logic [3:0]            store_mask;
    logic [31:0]           store_data, load_data;

    assign opcode = ir_q[6:0];
    assign rd     = ir_q[11:7];
    assign funct3 = ir_q[14:12];
    assign rs1    = ir_q[19:15];
    assign rs2    = ir_q[24:20];
    assign funct7 = ir_q[31:25];
    assign imm_i  = {{20{ir_q[31]}}, ir_q[31:20]};
    assign imm_s  = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
    assign imm_b  = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
    assign imm_u  = {ir_q[31:12], 12'h0};
    assign imm_j  = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};

    // Instruction decode: legality, operand selection and ALU operation
    always_comb begin
        legal      = 1'b0;
        is_load    = 1'b0;
        is_store   = 1'b0;
        is_branch  = 1'b0;
        is_jal     = 1'b0;
        is_jalr    = 1'b0;
        writes_rd  = 1'b0;
        src_a_pc   = 1'b0;
        src_a_zero = 1'b0;
        src_b_imm  = 1'b0;
        reg_src    = REG_SRC_ALU;
        imm        = imm_i;
        case (funct3)
            3'b001:  alu_op = ALU_SLL;
            3'b010:  alu_op = ALU_SLT;
            3'b011:  alu_op = ALU_SLTU;
            3'b100:  alu_op = ALU_XOR;
            3'b101:  alu_op = funct7[5] ? ALU_SRA : ALU_SRL;
            3'b110:  alu_op = ALU_OR;
            3'b111:  alu_op = ALU_AND;
            default: alu_op = ALU_ADD;
        endcase
        case (opcode)
            OPCODE_LUI: begin
                legal = 1'b1; writes_rd = 1'b1; src_a_zero = 1'b1; src_b_imm = 1'b1;
                imm = imm_u; alu_op = ALU_ADD;
            end
            OPCODE_AUIPC: begin
                legal = 1'b1; writes_rd = 1'b1; src_a_pc = 1'b1; src_b_imm = 1'b1;
                imm = imm_u; alu_op = ALU_ADD;
            end
            OPCODE_JAL: begin
                legal = 1'b1; writes_rd = 1'b1; is_jal = 1'b1; reg_src = REG_SRC_PC4; imm = imm_j;
            end
            OPCODE_JALR: begin
                legal = (funct3 == 3'b000); writes_rd = 1'b1; is_jalr = 1'b1; reg_src = REG_SRC_PC4;
            end
            OPCODE_BRANCH: begin
                legal = (funct3 != 3'b010) && (funct3 != 3'b011); is_branch = 1'b1; imm = imm_b;
            end
            OPCODE_LOAD: begin
                legal = (funct3 == MEM_RD_B) || (funct3 == MEM_RD_H) || (funct3 == MEM_RD_W) ||
                        (funct3 == MEM_RD_BU) || (funct3 == MEM_RD_HU);
                is_load = 1'b1; writes_rd = 1'b1; reg_src = REG_SRC_MEM;
            end
            OPCODE_STORE: begin
                legal = (funct3 <= MEM_RD_W); is_store = 1'b1; imm = imm_s;
            end
            OPCODE_OP_IMM: begin
                writes_rd = 1'b1; src_b_imm = 1'b1;
                if (funct3 == 3'b001)      legal = (funct7 == 7'h00);
                else if (funct3 == 3'b101) legal = (funct7 == 7'h00) || (funct7 == 7'h20);
                else                       legal = 1'b1;
                if (funct3 == 3'b000) alu_op = ALU_ADD;
            end
            OPCODE_OP: begin
                writes_rd = 1'b1;
                legal = (funct7 == 7'h00) ||
                        ((funct7 == 7'h20) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
                if (funct3 == 3'b000) alu_op = funct7[5] ? ALU_SUB : ALU_ADD;
            end
            default: legal = 1'b0;
        endcase
    end

    // Execute datapath: ALU, branch resolution, next PC and trap detection
    always_comb begin
        rs1_val   = (rs1 == 5'd0) ? 32'h0 : rf_q[rs1];
        rs2_val   = (rs2 == 5'd0) ? 32'h0 : rf_q[rs2];
        op_a      = src_a_zero ? 32'h0 : (src_a_pc ? pc_q : rs1_val);
        op_b      = src_b_imm ? imm : rs2_val;
        alu_res   = alu_eval(alu_op, op_a, op_b);
        pc4       = pc_q + 32'd4;
        eff       = DMEM_WIDTH'(rs1_val + imm);
        case (funct3)
            3'b000:  taken = (rs1_val == rs2_val);
            3'b001:  taken = (rs1_val != rs2_val);
            3'b100:  taken = ($signed(rs1_val) < $signed(rs2_val));
            3'b101:  taken = ($signed(rs1_val) >= $signed(rs2_val));
            3'b110:  taken = (rs1_val < rs2_val);
            3'b111:  taken = (rs1_val >= rs2_val);
            default: taken = 1'b0;
        endcase
        redirect  = is_jal || is_jalr || (is_branch && taken);
        if (is_jalr)       next_pc_d = (rs1_val + imm) & ~32'd1;
        else if (redirect) next_pc_d = pc_q + imm;
        else               next_pc_d = pc4;
        misalign_data = (is_load || is_store) &&
                        (((funct3[1:0] == 2'b01) && eff[0]) ||
                         ((funct3[1:0] == 2'b10) && (eff[1:0] != 2'b00)));
        misalign_pc   = redirect && (next_pc_d[1:0] != 2'b00);
        wb_d          = (reg_src == REG_SRC_PC4) ? pc4 : alu_res;
    end

    assign rf_we = (state_q == CPU_ST_WRITE_BACK) && writes_rd && (rd != 5'd0);

    rv32i_cpu_mc_mem_align u_mem_align (
        .funct3_i     (funct3),
        .byte_off_i   (eff[1:0]),
        .store_src_i  (rs2_val),
        .load_word_i  (data_read),
        .store_mask_o (store_mask),
        .store_data_o (store_data),
        .load_data_o  (load_data)
    );

    // Control FSM with registered port outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= CPU_ST_IDLE;
            pc_q         <= RESET_PC;
            inst_req_q   <= 1'b0;
            inst_addr_q  <= '0;
            data_req_q   <= 1'b0;
            data_addr_q  <= '0;
            data_we_q    <= 4'h0;
            data_write_q <= 32'h0;
            halted_q     <= 1'b0;
            trap_q       <= TRAP_NONE;
        end else begin
            case (state_q)
                CPU_ST_IDLE: begin
                    inst_req_q  <= 1'b1;
                    inst_addr_q <= IMEM_WIDTH'(pc_q);
                    state_q     <= CPU_ST_FETCH;
                end
                CPU_ST_FETCH: begin
                    if (inst_valid) begin
                        inst_req_q <= 1'b0;
                        state_q    <= CPU_ST_DECODE;
                    end
                end
                CPU_ST_DECODE: state_q <= CPU_ST_EXECUTE;
                CPU_ST_EXECUTE: begin
                    if (!legal) begin
                        state_q <= CPU_ST_HALT; halted_q <= 1'b1; trap_q <= TRAP_ILLEGAL;
                    end else if (misalign_data) begin
                        state_q <= CPU_ST_HALT; halted_q <= 1'b1; trap_q <= TRAP_MISALIGN_DATA;
                    end else if (misalign_pc) begin
                        state_q <= CPU_ST_HALT; halted_q <= 1'b1; trap_q <= TRAP_MISALIGN_PC;
                    end else if (is_load || is_store) begin
                        data_req_q   <= 1'b1;
                        data_addr_q  <= {eff[DMEM_WIDTH-1:2], 2'b00};
                        data_we_q    <= is_store ? store_mask : 4'h0;
                        data_write_q <= is_store ? store_data : 32'h0;
                        state_q      <= CPU_ST_MEM;
                    end else begin
                        state_q <= CPU_ST_WRITE_BACK;
                    end
                end
                CPU_ST_MEM: begin
                    if (data_valid) begin
                        data_req_q   <= 1'b0;
                        data_we_q    <= 4'h0;
                        data_write_q <= 32'h0;
                        state_q      <= CPU_ST_WRITE_BACK;
                    end
                end
                CPU_ST_WRITE_BACK: begin
                    pc_q        <= next_pc_q;
                    inst_req_q  <= 1'b1;
                    inst_addr_q <= IMEM_WIDTH'(next_pc_q);
                    state_q     <= CPU_ST_FETCH;
                end
                CPU_ST_HALT: state_q <= CPU_ST_HALT;
                default:     state_q <= CPU_ST_IDLE;
            endcase
        end
    end

    // Datapath capture registers and register file (not reset)
    always_ff @(posedge clk) begin
        if ((state_q == CPU_ST_FETCH) && inst_valid) ir_q <= instruction_data;
        if (state_q == CPU_ST_EXECUTE) begin
            next_pc_q <= next_pc_d;
            wb_q      <= wb_d;
        end
        if ((state_q == CPU_ST_MEM) && data_valid && is_load) wb_q <= load_data;
        if (rf_we) rf_q[rd] <= wb_q;
    end

    assign inst_req   = inst_req_q;
    assign inst_addr  = inst_addr_q;
    assign data_req   = data_req_q;
    assign data_addr  = data_addr_q;
    assign data_we    = data_we_q;
    assign data_write = data_write_q;
    assign halted     = halted_q;
    assign trap_cause = trap_q;

`ifdef RV32I_CPU_PERF_CNT_EN
    logic [63:0] cycle_q, instret_q;

    // Active-cycle and retired-instruction counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_q   <= 64'h0;
            instret_q <= 64'h0;
        end else begin
            if ((state_q != CPU_ST_IDLE) && (state_q != CPU_ST_HALT)) cycle_q <= cycle_q + 64'd1;
            if (state_q == CPU_ST_WRITE_BACK) instret_q <= instret_q + 64'd1;
        end
    end

    assign cycle_count   = cycle_q;
    assign instret_count = instret_q;
`endif

endmodule
